fpu_seq_ctrl: RTL and testbench
===============================

// Module: fpu_seq_ctrl
// PURPOSE
//  Multi-cycle FPU sequencer for the execute/memory stage. Detects long-latency FP ops
//  entering EX, stalls the pipeline for exactly the op's latency and holds the FPU select
//  stable. Captures the FPU result into a register and flags it for the ALU/FPU result mux.
//  Single-cycle FPU ops and integer ops pass through with no stall.
// PARAMETERS
//  LAT_ADD   3   cycles for fadd/fsub (sel 5'b00000/5'b00001)
//  LAT_MUL   4   cycles for fmul (sel 5'b00010)
//  LAT_DIV   16  cycles for fdiv (sel 5'b00011)
//  LAT_SQRT  16  cycles for fsqrt (sel 5'b00100); every other sel has latency 1
//  CNT_W     5   latency counter width; each LAT_* must satisfy 1 <= LAT <= 2**CNT_W+1
//  PERF_W    32  perf counter width (used only with FPU_SEQ_PERF_EN)
// PORTS
//  clk                input   1       rising-edge clock
//  rst                input   1       asynchronous, active-high reset
//  issue_valid        input   1       FP op present in EX this cycle (DSrc=1 instruction)
//  flush              input   1       kill the instruction in EX (branch/exception)
//  sel_fpu            input   5       FPU op select from decode
//  fpu_result         input   32      FPU Result output
//  stall              output  1       freeze IF/ID/EX registers and PC
//  fpu_sel            output  5       select driven to the FPU
//  result_valid       output  1       result_q holds the completed multi-cycle result
//  result_q           output  32      captured FPU result
//  busy               output  1       FSM not in IDLE
//  perf_stall_cycles  output  PERF_W  (FPU_SEQ_PERF_EN only) total cycles with stall=1
//  perf_ops           output  PERF_W  (FPU_SEQ_PERF_EN only) multi-cycle ops completed
// BEHAVIOUR
//  - lat(sel) is the combinational latency lookup; an op is multi-cycle iff lat > 1.
//  - FSM states: IDLE, BUSY, DONE. Reset (async): IDLE, cnt=0, sel_q=0, result_q=0.
//    Outputs after reset: stall=0, result_valid=0, busy=0, fpu_sel=sel_fpu.
//  - IDLE: issue_valid & !flush & lat>1 -> stall=1 comb., sel_q<=sel_fpu, cnt<=lat-2,
//    next BUSY. With lat==1 or !issue_valid: stay IDLE, stall=0.
//  - BUSY: stall=!flush. cnt!=0 -> cnt--. cnt==0 -> result_q<=fpu_result, next DONE.
//    flush -> next IDLE, result_q unchanged, no DONE.
//  - DONE: stall=0, result_valid=!flush, one cycle; pipeline advances this cycle; next IDLE.
//    issue_valid in DONE is ignored (it is still the completed instruction).
//  - Timing: issue at cycle T -> stall high T..T+L-1 (exactly L cycles), capture at
//    edge ending T+L-1, result_valid=1 at T+L. A new op may issue at T+L+1.
//  - fpu_sel = sel_fpu in IDLE; sel_q in BUSY/DONE (operands/select stable while stalled).
//  - flush in IDLE suppresses issue. flush in the issue cycle: no state change, stall=0.
//  - busy = (state != IDLE). result_valid is 0 in IDLE and BUSY.
// CONFIGURATION
//  FPU_SEQ_PERF_EN defined: perf_stall_cycles increments each cycle stall=1; perf_ops
//    increments on each BUSY->DONE transition whose DONE cycle has flush=0 (flushed
//    DONE not counted). Both wrap at 2**PERF_W, reset to 0, never cleared otherwise.
//  Undefined: the perf ports and counters do not exist.
// TESTING
//  - fadd sel=00000, issue_valid=1 at cyc0, fpu_result=32'h40400000 at cyc2 -> stall=1
//    cyc0-2, result_valid=1 cyc3, result_q=32'h40400000, busy 0 at cyc4.
//  - fdiv sel=00011 -> stall exactly 16 cycles, fpu_sel=00011 throughout even if sel_fpu
//    changes to 00000 at cyc5; result_valid at cyc16.
//  - sel=01000 (single-cycle) with issue_valid=1 for 10 cycles -> stall=0, busy=0 always.
//  - fmul issued cyc0, flush=1 cyc2 -> stall=0 cyc2, IDLE cyc3, no result_valid, result_q held.
//  - rst pulsed mid-fdiv (cyc7) -> outputs reset asynchronously, next fadd behaves as test 1.
//  - FPU_SEQ_PERF_EN: fadd, fmul, flushed fdiv (flush cyc4) -> perf_ops=2,
//    perf_stall_cycles=3+4+4=11.

Source files
------------

// File: rtl/fpu_seq_ctrl.sv
// Multi-cycle FPU sequencer: stalls EX for the op latency, holds the FPU select and captures the result.
// Optional perf counters are enabled with `define FPU_SEQ_PERF_EN.
module fpu_seq_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int CNT_W    = 5,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              flush,
  input  logic [4:0]        sel_fpu,
  input  logic [31:0]       fpu_result,
  output logic              stall,
  output logic [4:0]        fpu_sel,
  output logic              result_valid,
  output logic [31:0]       result_q,
  output logic              busy
`ifdef FPU_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_ops
`endif
);

  // state | meaning
  // IDLE  | no multi-cycle op in flight; select passes straight through
  // BUSY  | counting down the op latency, pipeline stalled
  // DONE  | result captured, result_valid for one cycle
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [4:0]         r_sel, w_sel_nxt;
  logic [31:0]        r_result, w_result_nxt;
  logic [CNT_W:0]     w_lat;
  logic [CNT_W:0]     w_lat_m2;
  logic               w_multi;

  always_comb begin
    case (sel_fpu)
      5'b00000, 5'b00001: w_lat = (CNT_W+1)'(LAT_ADD);
      5'b00010:           w_lat = (CNT_W+1)'(LAT_MUL);
      5'b00011:           w_lat = (CNT_W+1)'(LAT_DIV);
      5'b00100:           w_lat = (CNT_W+1)'(LAT_SQRT);
      default:            w_lat = (CNT_W+1)'(1);
    endcase
  end

  assign w_multi  = (w_lat > (CNT_W+1)'(1));
  assign w_lat_m2 = w_lat - (CNT_W+1)'(2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_result_nxt = r_result;
    stall        = 1'b0;
    result_valid = 1'b0;
    fpu_sel      = r_sel;
    case (r_state)
      S_IDLE: begin
        fpu_sel = sel_fpu;
        if (issue_valid && !flush && w_multi) begin
          stall       = 1'b1;
          w_sel_nxt   = sel_fpu;
          w_cnt_nxt   = w_lat_m2[CNT_W-1:0];
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = !flush;
        // a flush abandons the op; the previous result stays in result_q
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_result_nxt = fpu_result;
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        result_valid = !flush;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign result_q = r_result;

`ifdef FPU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_ops          <= '0;
    end else begin
      if (stall)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (r_state == S_DONE && !flush)
        perf_ops <= perf_ops + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed self-checking bench for fpu_seq_ctrl (perf checks compiled in with FPU_SEQ_PERF_EN).
module tb_fpu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        flush;
  logic [4:0]  sel_fpu;
  logic [31:0] fpu_result;
  logic        stall;
  logic [4:0]  fpu_sel;
  logic        result_valid;
  logic [31:0] result_q;
  logic        busy;
`ifdef FPU_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_ops;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  fpu_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .flush        (flush),
    .sel_fpu      (sel_fpu),
    .fpu_result   (fpu_result),
    .stall        (stall),
    .fpu_sel      (fpu_sel),
    .result_valid (result_valid),
    .result_q     (result_q),
    .busy         (busy)
`ifdef FPU_SEQ_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_ops          (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // one cycle: drive inputs just after the edge, leave outputs settled for checking
  task automatic cyc(input logic iv, input logic fl, input logic [4:0] s, input logic [31:0] r);
    @(posedge clk);
    #1;
    issue_valid = iv;
    flush       = fl;
    sel_fpu     = s;
    fpu_result  = r;
    #1;
  endtask

  task automatic t_fadd(input string tag);
    cyc(1'b1, 1'b0, 5'b00000, 32'h0);
    chk({tag, " c0 stall"}, 32'(stall), 32'd1);
    chk({tag, " c0 busy"}, 32'(busy), 32'd0);
    cyc(1'b1, 1'b0, 5'b00000, 32'h0);
    chk({tag, " c1 stall"}, 32'(stall), 32'd1);
    chk({tag, " c1 busy"}, 32'(busy), 32'd1);
    cyc(1'b1, 1'b0, 5'b00000, 32'h40400000);
    chk({tag, " c2 stall"}, 32'(stall), 32'd1);
    chk({tag, " c2 rv"}, 32'(result_valid), 32'd0);
    cyc(1'b1, 1'b0, 5'b00000, 32'h0);
    chk({tag, " c3 stall"}, 32'(stall), 32'd0);
    chk({tag, " c3 rv"}, 32'(result_valid), 32'd1);
    chk({tag, " c3 result_q"}, result_q, 32'h40400000);
    cyc(1'b0, 1'b0, 5'b00000, 32'h0);
    chk({tag, " c4 busy"}, 32'(busy), 32'd0);
    chk({tag, " c4 rv"}, 32'(result_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] s, input int lat, input logic [31:0] res);
    int stalls;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0, s, (k == lat - 1) ? res : 32'hBAD00000);
      if (stall) stalls++;
      else break;
    end
    chk({tag, " stall cycles"}, 32'(stalls), 32'(lat));
    chk({tag, " rv"}, 32'(result_valid), 32'd1);
    chk({tag, " result_q"}, result_q, res);
    cyc(1'b0, 1'b0, 5'b00000, 32'h0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int stalls;
    rst = 1'b1; issue_valid = 1'b0; flush = 1'b0; sel_fpu = 5'b00110; fpu_result = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst rv", 32'(result_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result_q", result_q, 32'h0);
    chk("rst fpu_sel", 32'(fpu_sel), 32'd6);

    t_fadd("fadd");

    // fdiv: select must stay 00011 even after sel_fpu changes
    stalls = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, (k >= 5) ? 5'b00000 : 5'b00011, (k == 15) ? 32'h3F000000 : 32'hDEADBEEF);
      if (stall) stalls++;
      if (k == 0 || k == 5 || k == 15) chk($sformatf("fdiv c%0d fpu_sel", k), 32'(fpu_sel), 32'd3);
    end
    chk("fdiv stall cycles", 32'(stalls), 32'd16);
    cyc(1'b1, 1'b0, 5'b00000, 32'h0);
    chk("fdiv c16 stall", 32'(stall), 32'd0);
    chk("fdiv c16 rv", 32'(result_valid), 32'd1);
    chk("fdiv c16 result_q", result_q, 32'h3F000000);
    cyc(1'b0, 1'b0, 5'b00000, 32'h0);

    // single-cycle op never stalls
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, 5'b01000, 32'h0);
      if (stall || busy) stalls++;
    end
    chk("single stall/busy", 32'(stalls), 32'd0);
    chk("single fpu_sel", 32'(fpu_sel), 32'd8);

    // fmul flushed in its third cycle
    cyc(1'b1, 1'b0, 5'b00010, 32'h11111111);
    chk("fmulfl c0 stall", 32'(stall), 32'd1);
    cyc(1'b1, 1'b0, 5'b00010, 32'h11111111);
    chk("fmulfl c1 stall", 32'(stall), 32'd1);
    cyc(1'b1, 1'b1, 5'b00010, 32'h11111111);
    chk("fmulfl c2 stall", 32'(stall), 32'd0);
    cyc(1'b0, 1'b0, 5'b00000, 32'h11111111);
    chk("fmulfl c3 busy", 32'(busy), 32'd0);
    chk("fmulfl c3 rv", 32'(result_valid), 32'd0);
    chk("fmulfl c3 result_q", result_q, 32'h3F000000);

    // flush in the issue cycle suppresses the op
    cyc(1'b1, 1'b1, 5'b00011, 32'h0);
    chk("issfl stall", 32'(stall), 32'd0);
    cyc(1'b0, 1'b0, 5'b00000, 32'h0);
    chk("issfl busy", 32'(busy), 32'd0);

    // remaining latency classes, including the fsub alias
    run_op("fsub", 5'b00001, 3, 32'hC0000000);
    run_op("fmul", 5'b00010, 4, 32'h40800000);
    run_op("fsqrt", 5'b00100, 16, 32'h3FB504F3);

    // async reset in the middle of an fdiv
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 5'b00011, 32'h0);
    #1;
    rst = 1'b1; issue_valid = 1'b0; sel_fpu = 5'b00111;
    #1;
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst rv", 32'(result_valid), 32'd0);
    chk("midrst result_q", result_q, 32'h0);
    chk("midrst fpu_sel", 32'(fpu_sel), 32'd7);
    @(posedge clk);
    #1 rst = 1'b0;
    t_fadd("fadd2");

`ifdef FPU_SEQ_PERF_EN
    @(posedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("perf rst stall", perf_stall_cycles, 32'd0);
    chk("perf rst ops", perf_ops, 32'd0);
    run_op("pfadd", 5'b00000, 3, 32'h1);
    run_op("pfmul", 5'b00010, 4, 32'h2);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 5'b00011, 32'h0);
    cyc(1'b1, 1'b1, 5'b00011, 32'h0);
    cyc(1'b0, 1'b0, 5'b00000, 32'h0);
    chk("perf ops", perf_ops, 32'd2);
    chk("perf stall", perf_stall_cycles, 32'd11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
